// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - run/step/breakpoint sequencer driving the MIPS core clock enable
module mips_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int RUN_DIV         = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       key,
    input  logic [1:0]       sw,
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    output logic             cpu_en,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [3:0]       leds
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DVW = $clog2(RUN_DIV + 1);

    typedef enum logic [1:0] {PAUSE = 2'd0, STEP = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;

    logic [1:0]     sync1, sync2, deb, press;
    logic [DBW-1:0] dcnt [2];
    state_t         state;
    logic [DVW-1:0] div;
    logic           go, stop;

    assign go   = press[0];
    assign stop = press[1];

    // press[i] fires only when the accepted level flips from released to pressed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            deb   <= 2'b11;
            press <= 2'b00;
            for (int i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            press <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]   <= sync2[i];
                    dcnt[i]  <= '0;
                    press[i] <= deb[i];
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    function automatic logic [3:0] led_of(state_t s);
        return 4'b0001 << s;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= PAUSE;
            leds   <= 4'b0001;
            cpu_en <= 1'b0;
            div    <= '0;
        end else begin
            cpu_en <= 1'b0;
            case (state)
                PAUSE: begin
                    if (!stop && go) begin
                        if (sw[0]) begin
                            state <= RUN;
                            leds  <= led_of(RUN);
                            div   <= '0;
                        end else begin
                            state  <= STEP;
                            leds   <= led_of(STEP);
                            cpu_en <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    state <= PAUSE;
                    leds  <= led_of(PAUSE);
                end
                RUN: begin
                    if (stop) begin
                        state <= PAUSE;
                        leds  <= led_of(PAUSE);
                    end else if (div == DVW'(RUN_DIV - 1)) begin
                        div <= '0;
                        // breakpoint halts before the matching instruction executes
                        if (sw[1] && pc == bp_addr) begin
                            state <= HALT;
                            leds  <= led_of(HALT);
                        end else begin
                            cpu_en <= 1'b1;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                HALT: begin
                    if (stop) begin
                        state <= PAUSE;
                        leds  <= led_of(PAUSE);
                    end else if (go) begin
                        state  <= STEP;
                        leds   <= led_of(STEP);
                        cpu_en <= 1'b1;
                    end
                end
                default: begin
                    state <= PAUSE;
                    leds  <= led_of(PAUSE);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_cnt <= '0;
        end else if (cpu_en && !(&instr_cnt)) begin
            instr_cnt <= instr_cnt + 1'b1;
        end
    end
endmodule
